// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage; owns the HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix/commit cycle.
//
// state | meaning
// IDLE  | waiting for start_e; MTHI/MTLO writes honoured here
// CALC  | PC_BITS iterations of multiply or divide
// FIX   | sign correction and HI/LO commit
module muldiv_sequencer #(
    parameter int PC_BITS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_e,
    input  logic [1:0]         op_e,
    input  logic [PC_BITS-1:0] src_a_e,
    input  logic [PC_BITS-1:0] src_b_e,
    input  logic               abort_e,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [PC_BITS-1:0] wr_data,
    output logic               busy_e,
    output logic               done_e,
    output logic [PC_BITS-1:0] hi_out,
    output logic [PC_BITS-1:0] lo_out
);
    localparam int W  = PC_BITS;
    localparam int CW = $clog2(PC_BITS) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_r;
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   a_raw;
    logic [W-1:0]   m_r;
    logic [2*W-1:0] acc;

    logic           in_signed;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     add_sum;
    logic [W:0]     trial;
    logic [2*W-1:0] acc_next;
    logic           r_signed;
    logic           r_div;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    always_comb begin
        in_signed = ~op_e[0];
        mag_a = (in_signed && src_a_e[W-1]) ? -src_a_e : src_a_e;
        mag_b = (in_signed && src_b_e[W-1]) ? -src_b_e : src_b_e;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m_r} : '0);
        trial    = acc[2*W-1:W-1] - {1'b0, m_r};
        acc_next = '0;
        if (!op_r[1])
            acc_next = {add_sum, acc[W-1:1]};
        else if (!trial[W])
            acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_next = {acc[2*W-2:0], 1'b0};
    end

    always_comb begin
        r_signed = ~op_r[0];
        r_div    = op_r[1];
        prod     = (r_signed && (sign_a ^ sign_b)) ? -acc : acc;
        quot     = (r_signed && (sign_a ^ sign_b)) ? -acc[W-1:0] : acc[W-1:0];
        rem      = (r_signed && sign_a) ? -acc[2*W-1:W] : acc[2*W-1:W];
        res_hi   = prod[2*W-1:W];
        res_lo   = prod[W-1:0];
        if (r_div) begin
            if (m_r == '0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_raw  <= '0;
            m_r    <= '0;
            acc    <= '0;
            busy_e <= 1'b0;
            done_e <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            done_e <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi_out <= wr_data;
                    if (lo_we) lo_out <= wr_data;
                    if (start_e && !abort_e) begin
                        op_r   <= op_e;
                        sign_a <= src_a_e[W-1];
                        sign_b <= src_b_e[W-1];
                        a_raw  <= src_a_e;
                        m_r    <= op_e[1] ? mag_b : mag_a;
                        acc    <= {{W{1'b0}}, (op_e[1] ? mag_a : mag_b)};
                        cnt    <= '0;
                        busy_e <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (abort_e) begin
                        busy_e <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(W - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    busy_e <= 1'b0;
                    state  <= IDLE;
                    if (!abort_e) begin
                        hi_out <= res_hi;
                        lo_out <= res_lo;
                        done_e <= 1'b1;
                    end
                end
                default: begin
                    busy_e <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_e = 1'b0;
    logic [1:0]  op_e = '0;
    logic [31:0] src_a_e = '0;
    logic [31:0] src_b_e = '0;
    logic        abort_e = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy_e;
    logic        done_e;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_sequencer #(.PC_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_e(start_e), .op_e(op_e),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .abort_e(abort_e),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy_e(busy_e), .done_e(done_e), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            2'd0: begin p = sa * sb; return p; end
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 0) return {a, 32'hffffffff};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hffffffff};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Start an op in the current cycle and follow it to done_e. At cycle 'poke'
    // a competing start plus an LO write is driven; both must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
        logic [63:0] exp;
        int cyc, busy_cnt, unstable;
        bit got;
        exp = ref_model(op, a, b);
        op_e = op; src_a_e = a; src_b_e = b; start_e = 1'b1;
        tick();
        start_e = 1'b0;
        cyc = 1; busy_cnt = 0; unstable = 0; got = 0;
        while (!got && cyc < 60) begin
            if (done_e) got = 1;
            else begin
                if (busy_e) busy_cnt++;
                if (hi_out !== hi_m || lo_out !== lo_m) unstable++;
                if (cyc == poke) begin
                    start_e = 1'b1; op_e = 2'd3; src_a_e = 32'd1; src_b_e = 32'd1;
                    lo_we = 1'b1; wr_data = 32'h5555;
                end else begin
                    start_e = 1'b0; lo_we = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        start_e = 1'b0; lo_we = 1'b0;
        check({tag, " latency"}, cyc, 34);
        check({tag, " busy_cycles"}, busy_cnt, 33);
        check({tag, " busy_at_done"}, busy_e, 0);
        check({tag, " stable_while_busy"}, unstable, 0);
        check({tag, " hi"}, hi_out, exp[63:32]);
        check({tag, " lo"}, lo_out, exp[31:0]);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
    endtask

    initial begin
        int done_seen;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        #12;
        check("reset busy", busy_e, 0);
        check("reset done", done_e, 0);
        check("reset hi", hi_out, 0);
        check("reset lo", lo_out, 0);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", 2'd1, 32'hffffffff, 32'hffffffff, -1);
        check("multu_max hi const", hi_out, 32'hfffffffe);
        check("multu_max lo const", lo_out, 32'h00000001);
        run_op("mult_neg", 2'd0, 32'hfffffffd, 32'd7, -1);
        check("mult_neg lo const", lo_out, 32'hffffffeb);
        run_op("div_neg", 2'd2, 32'hfffffff9, 32'd2, -1);
        check("div_neg lo const", lo_out, 32'hfffffffd);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hffffffff, -1);
        check("div_ovf lo const", lo_out, 32'h80000000);
        run_op("divu_zero", 2'd3, 32'h1234, 32'd0, -1);
        check("divu_zero hi const", hi_out, 32'h1234);
        run_op("div_zero", 2'd2, 32'hfffffff0, 32'd0, -1);
        check("div_zero lo const", lo_out, 32'hffffffff);

        // MTHI in IDLE, then a DIVU with a start and LO write arriving mid-op
        hi_we = 1'b1; wr_data = 32'hAAAA;
        tick();
        hi_we = 1'b0;
        check("mthi", hi_out, 32'hAAAA);
        hi_m = 32'hAAAA;
        run_op("divu_ignore", 2'd3, 32'd100, 32'd7, 5);
        check("divu_ignore hi const", hi_out, 32'd2);
        check("divu_ignore lo const", lo_out, 32'd14);

        // Abort in CALC with a simultaneous start; HI write at the start edge sticks
        op_e = 2'd1; src_a_e = 32'd5; src_b_e = 32'd5; start_e = 1'b1;
        hi_we = 1'b1; wr_data = 32'h1357;
        tick();
        start_e = 1'b0; hi_we = 1'b0;
        check("mthi_at_start", hi_out, 32'h1357);
        hi_m = 32'h1357;
        for (int i = 1; i < 10; i++) tick();
        abort_e = 1'b1; start_e = 1'b1; src_a_e = 32'd9; src_b_e = 32'd9;
        tick();
        abort_e = 1'b0; start_e = 1'b0;
        check("abort busy_next", busy_e, 0);
        done_seen = done_e;
        tick();
        done_seen += done_e;
        check("abort busy_later", busy_e, 0);
        check("abort no_done", done_seen, 0);
        check("abort hi", hi_out, hi_m);
        check("abort lo", lo_out, lo_m);
        run_op("after_abort", 2'd1, 32'd5, 32'd5, -1);
        check("after_abort lo const", lo_out, 32'd25);

        // Abort in FIX: nothing commits
        op_e = 2'd0; src_a_e = 32'd1000; src_b_e = 32'd1000; start_e = 1'b1;
        tick();
        start_e = 1'b0;
        for (int i = 1; i < 33; i++) tick();
        abort_e = 1'b1;
        tick();
        abort_e = 1'b0;
        check("fix_abort done", done_e, 0);
        check("fix_abort busy", busy_e, 0);
        check("fix_abort lo", lo_out, lo_m);

        // Random ops, back-to-back
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hffffffff;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", n), rop, ra, rb, -1);
        end

        // Async reset in the middle of a DIV
        op_e = 2'd2; src_a_e = 32'hdeadbeef; src_b_e = 32'd3; start_e = 1'b1;
        tick();
        start_e = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid busy", busy_e, 0);
        check("rst_mid done", done_e, 0);
        check("rst_mid hi", hi_out, 0);
        check("rst_mid lo", lo_out, 0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            done_seen += done_e;
        end
        check("rst_mid no_done", done_seen, 0);
        check("rst_mid idle", busy_e, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide controller for the execute stage. It accepts MULT/MULTU/DIV/DIVU requests from decode/execute and iterates a shift-add multiplier or restoring divider one bit per cycle. While it runs it holds the pipeline via a busy/stall output, then commits the result into architectural HI/LO registers. It also owns HI/LO for MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- PC_BITS, 32, operand and HI/LO width (datapath word width)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_e  input  1  request; sampled only in IDLE
- op_e  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a_e  input  PC_BITS  multiplicand / dividend
- src_b_e  input  PC_BITS  multiplier / divisor
- abort_e  input  1  pipeline flush; cancels the in-flight operation
- hi_we, lo_we  input  1 each  MTHI/MTLO write enables
- wr_data  input  PC_BITS  MTHI/MTLO data
- busy_e  output  1  operation in flight; drives the execute stall
- done_e  output  1  one-cycle pulse; HI/LO just committed
- hi_out, lo_out  output  PC_BITS each  HI/LO register contents

## Operation
- States: IDLE, CALC, FIX.
- IDLE with start_e=1 and abort_e=0:
  - latch op, the operand sign bits, and operands;
  - for signed ops, latch magnitudes of the operands;
  - clear the iteration counter; go to CALC.
- CALC: one iteration per cycle; counter increments; after PC_BITS iterations go to FIX.
  - Multiply: 2*PC_BITS-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor; quotient bit = no borrow.
- FIX: apply sign correction; write HI/LO; go to IDLE.
- Sign rules for signed ops:
  - Product is negated (2*PC_BITS-wide two's complement) when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - -2^(PC_BITS-1) / -1 gives lo = 0x80000000, hi = 0; no trap.
- Result mapping:
  - Multiply: hi = upper PC_BITS of the product, lo = lower PC_BITS.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (both signednesses): CALC and FIX still run for the full latency. Result is lo = all ones, hi = src_a as latched (no sign correction).
- abort_e=1 in CALC or FIX:
  - next state IDLE; HI/LO unchanged; no done_e.
  - A start_e in that same cycle is ignored.
- start_e while busy: ignored, no queueing.
- hi_we/lo_we:
  - Honoured only in IDLE, including the cycle start_e is accepted; the write lands at that edge. A later FIX commit overwrites it.
  - Ignored while busy_e=1.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0.
  - Outputs: busy_e=0, done_e=0, hi_out=0, lo_out=0.
  - Internal operand/accumulator registers are cleared.
  - Reset mid-operation discards it with no done_e.
- Cycle numbering: cycle 0 = the cycle start_e is high in IDLE.
- busy_e is registered and high in cycles 1 through PC_BITS+1 (CALC × PC_BITS, FIX × 1).
- HI/LO update at the edge ending FIX.
- done_e is high in cycle PC_BITS+2 only, i.e. cycle 34 for PC_BITS=32. hi_out/lo_out already hold the new values in that cycle.
- busy_e=0 in cycle PC_BITS+2, so a new start_e is accepted in that cycle. Back-to-back throughput is one op per PC_BITS+2 cycles.
- hi_out/lo_out are direct register outputs (zero-latency MFHI/MFLO) and are stable while busy.
- abort_e sampled in cycle k: busy_e=0 from cycle k+1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy_e high cycles 1–33, done_e in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 and DIV 0xFFFFFFF0 / 0 -> lo=0xFFFFFFFF, hi=src_a; done_e in cycle 34.
- MTHI 0xAAAA, then start DIVU 100/7 with a second start_e (operands 1/1) in cycle 5 -> second start ignored; final hi=2, lo=14.
- Start MULTU 5×5; assert abort_e in cycle 10 together with start_e -> busy_e=0 from cycle 11, no done_e, HI/LO unchanged. Then a fresh start in cycle 12 completes in cycle 46 with hi=0, lo=25.
- Drop rst_n in cycle 20 of a DIV -> busy_e, done_e, hi_out, lo_out all 0 immediately (asynchronously), no done_e after release.
